// File: rtl/imem_responder.sv
// Instruction memory responder: host image load port plus combinational fetch port.
// Optional parity protection enabled with `define IMEM_PARITY_EN.
module imem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        hold_cpu,
    input  logic [31:0] iaddr,
    output logic [31:0] data,
    output logic [15:0] ld_count,
    output logic        err_ld,
    output logic        err_fetch,
    output logic        err_par
);

    localparam int AW = $clog2(DEPTH_WORDS);
`ifdef IMEM_PARITY_EN
    localparam int MW = 33;
`else
    localparam int MW = 32;
`endif

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic        hold_q, hold_d;
    logic [15:0] ld_count_q, ld_count_d;
    logic        err_ld_q, err_ld_d;
    logic        err_fetch_q, err_fetch_d;
    logic        err_par_q, err_par_d;

    logic [MW-1:0] mem_q [DEPTH_WORDS];
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;

    logic        xfer;
    logic        ld_in_range;
    logic [31:0] off;
    logic [29:0] idx;
    logic        fetch_legal;
    logic        par_ok;

    assign ld_ready    = (state_q == LOAD);
    assign xfer        = ld_valid & ld_ready;
    assign ld_in_range = (ld_addr < 32'(DEPTH_WORDS));

    assign off         = iaddr - BASE_ADDR;
    assign idx         = off[31:2];
    assign fetch_legal = (off[1:0] == 2'b00) &&
                         ({2'b00, idx} < 32'(DEPTH_WORDS));
    assign rd_word     = mem_q[idx[AW-1:0]];

`ifdef IMEM_PARITY_EN
    assign wr_word = {^ld_data, ld_data};
    assign par_ok  = ~(^rd_word);
`else
    assign wr_word = ld_data;
    assign par_ok  = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        hold_d      = (state_q == LOAD);
        ld_count_d  = ld_count_q;
        err_ld_d    = err_ld_q;
        err_fetch_d = err_fetch_q;
        err_par_d   = err_par_q;
        data        = 32'h0;

        unique case (state_q)
            LOAD: begin
                if (xfer) begin
                    if (ld_count_q != 16'hFFFF) begin
                        ld_count_d = ld_count_q + 16'd1;
                    end
                    if (!ld_in_range) begin
                        err_ld_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!fetch_legal) begin
                    err_fetch_d = 1'b1;
                end else if (!par_ok) begin
                    err_par_d = 1'b1;
                end else begin
                    data = rd_word[31:0];
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD;
            hold_q      <= 1'b1;
            ld_count_q  <= 16'h0;
            err_ld_q    <= 1'b0;
            err_fetch_q <= 1'b0;
            err_par_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            ld_count_q  <= ld_count_d;
            err_ld_q    <= err_ld_d;
            err_fetch_q <= err_fetch_d;
            err_par_q   <= err_par_d;
        end
    end

    // Image survives reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (xfer && ld_in_range) begin
            mem_q[ld_addr[AW-1:0]] <= wr_word;
        end
    end

    assign hold_cpu  = hold_q;
    assign ld_count  = ld_count_q;
    assign err_ld    = err_ld_q;
    assign err_fetch = err_fetch_q;
    assign err_par   = err_par_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: load, gaps, range errors, reset mid-load.
// Parity scenario compiled only with IMEM_PARITY_EN.
module tb_imem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        hold_cpu;
    logic [31:0] iaddr;
    logic [31:0] data;
    logic [15:0] ld_count;
    logic        err_ld;
    logic        err_fetch;
    logic        err_par;

    int n_run;
    int n_fail;

    imem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .hold_cpu (hold_cpu),
        .iaddr    (iaddr),
        .data     (data),
        .ld_count (ld_count),
        .err_ld   (err_ld),
        .err_fetch(err_fetch),
        .err_par  (err_par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d,
                             input logic l);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_last  = l;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_run++;
        if ({ld_ready, hold_cpu, ld_count} !== {1'b1, 1'b1, 16'h0}) begin
            $display("FAIL reset_ctl: got rdy=%b hold=%b cnt=%0d want 1 1 0",
                     ld_ready, hold_cpu, ld_count);
            n_fail++;
        end
        n_run++;
        if ({err_ld, err_fetch, err_par} !== 3'b000) begin
            $display("FAIL reset_flags: got %b%b%b want 000",
                     err_ld, err_fetch, err_par);
            n_fail++;
        end
        release_reset();
    endtask

    task automatic test_load_with_gap();
        load_word(32'd0, 32'h20080001, 1'b0);
        load_word(32'd1, 32'h21080001, 1'b0);
        load_word(32'd2, 32'h00000000, 1'b0);
        ld_addr = 32'd1;
        ld_data = 32'hDEADBEEF;
        iaddr   = 32'd2;
        step();
        step();
        step();
        n_run++;
        if (ld_count !== 16'd3) begin
            $display("FAIL gap_count: got %0d want 3", ld_count);
            n_fail++;
        end
        n_run++;
        if (data !== 32'h0 || err_fetch !== 1'b0) begin
            $display("FAIL load_fetch: got data=%h errf=%b want 0 0",
                     data, err_fetch);
            n_fail++;
        end
        load_word(32'd3, 32'hAC080000, 1'b1);
        n_run++;
        if ({ld_count, ld_ready, hold_cpu} !== {16'd4, 1'b0, 1'b1}) begin
            $display("FAIL last_xfer: got cnt=%0d rdy=%b hold=%b want 4 0 1",
                     ld_count, ld_ready, hold_cpu);
            n_fail++;
        end
        iaddr = 32'd8;
        step();
        n_run++;
        if (hold_cpu !== 1'b0) begin
            $display("FAIL hold_fall: got %b want 0", hold_cpu);
            n_fail++;
        end
        n_run++;
        if (data !== 32'h0) begin
            $display("FAIL fetch_8: got %h want 00000000", data);
            n_fail++;
        end
        iaddr = 32'd4;
        #1;
        n_run++;
        if (data !== 32'h21080001) begin
            $display("FAIL fetch_4: got %h want 21080001", data);
            n_fail++;
        end
        iaddr = 32'd0;
        #1;
        n_run++;
        if (data !== 32'h20080001) begin
            $display("FAIL fetch_0: got %h want 20080001", data);
            n_fail++;
        end
        iaddr = 32'd12;
        #1;
        n_run++;
        if (data !== 32'hAC080000) begin
            $display("FAIL fetch_12: got %h want AC080000", data);
            n_fail++;
        end
        step();
        n_run++;
        if ({err_fetch, err_par, err_ld} !== 3'b000) begin
            $display("FAIL legal_flags: got %b%b%b want 000",
                     err_fetch, err_par, err_ld);
            n_fail++;
        end
    endtask

    task automatic test_fetch_err();
        iaddr = BASE + 32'd2;
        #1;
        n_run++;
        if (data !== 32'h0 || err_fetch !== 1'b0) begin
            $display("FAIL misalign: got data=%h errf=%b want 0 0",
                     data, err_fetch);
            n_fail++;
        end
        step();
        n_run++;
        if (err_fetch !== 1'b1) begin
            $display("FAIL errf_set: got %b want 1", err_fetch);
            n_fail++;
        end
        iaddr = BASE + DEPTH * 4;
        #1;
        n_run++;
        if (data !== 32'h0) begin
            $display("FAIL oor_fetch: got %h want 0", data);
            n_fail++;
        end
        iaddr = 32'd0;
        step();
        step();
        n_run++;
        if (err_fetch !== 1'b1 || data !== 32'h20080001) begin
            $display("FAIL errf_sticky: got errf=%b data=%h want 1 20080001",
                     err_fetch, data);
            n_fail++;
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        release_reset();
        load_word(32'd0, 32'h11111111, 1'b0);
        iaddr = 32'd0;
        #1;
        n_run++;
        if (data !== 32'h0) begin
            $display("FAIL load_data0: got %h want 0", data);
            n_fail++;
        end
        load_word(32'd1, 32'h22222222, 1'b0);
        do_reset();
        n_run++;
        if ({ld_count, ld_ready, hold_cpu} !== {16'd0, 1'b1, 1'b1}) begin
            $display("FAIL mid_reset: got cnt=%0d rdy=%b hold=%b want 0 1 1",
                     ld_count, ld_ready, hold_cpu);
            n_fail++;
        end
        release_reset();
        load_word(32'd2, 32'h33333333, 1'b0);
        load_word(32'd3, 32'h44444444, 1'b1);
        step();
        n_run++;
        if (ld_count !== 16'd2 || {err_ld, err_fetch, err_par} !== 3'b000) begin
            $display("FAIL reload: got cnt=%0d flags=%b%b%b want 2 000",
                     ld_count, err_ld, err_fetch, err_par);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp;
            exp = {8{4'(i + 1)}};
            iaddr = 32'(i * 4);
            #1;
            n_run++;
            if (data !== exp) begin
                $display("FAIL reload_w%0d: got %h want %h", i, data, exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_err_ld();
        do_reset();
        release_reset();
        load_word(32'(DEPTH), 32'hBADBAD00, 1'b1);
        n_run++;
        if ({err_ld, ld_ready, ld_count} !== {1'b1, 1'b0, 16'd1}) begin
            $display("FAIL err_ld: got errl=%b rdy=%b cnt=%0d want 1 0 1",
                     err_ld, ld_ready, ld_count);
            n_fail++;
        end
        iaddr = 32'd0;
        step();
        n_run++;
        if (data !== 32'h11111111 || err_fetch !== 1'b0) begin
            $display("FAIL err_ld_mem: got data=%h errf=%b want 11111111 0",
                     data, err_fetch);
            n_fail++;
        end
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        dut.mem_q[1] = dut.mem_q[1] ^ 33'h1;
        iaddr = 32'd4;
        #1;
        n_run++;
        if (data !== 32'h0) begin
            $display("FAIL par_data: got %h want 0", data);
            n_fail++;
        end
        step();
        n_run++;
        if (err_par !== 1'b1) begin
            $display("FAIL par_flag: got %b want 1", err_par);
            n_fail++;
        end
        iaddr = 32'd0;
        #1;
        n_run++;
        if (data !== 32'h11111111) begin
            $display("FAIL par_w0: got %h want 11111111", data);
            n_fail++;
        end
    endtask
`else
    task automatic test_parity();
        n_run++;
        if (err_par !== 1'b0) begin
            $display("FAIL par_off: got %b want 0", err_par);
            n_fail++;
        end
    endtask
`endif

    initial begin
        n_run    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_addr  = 32'h0;
        ld_data  = 32'h0;
        ld_last  = 1'b0;
        iaddr    = 32'h0;
        test_reset();
        test_load_with_gap();
        test_fetch_err();
        test_reset_midload();
        test_err_ld();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
